ksa_scheduler: RTL
==================

# ksa_scheduler

Runs the RC4 key-scheduling pass over the 256-byte scratch (S) memory. It optionally fills the memory with the identity permutation first, then performs the 256 key-driven swaps. It sits directly upstream of the decrypter: `finish` from this block gates `start` of the decrypter. The decrypter reads the permuted S array this block leaves in scratch memory.

## Interface
- `DATA_WIDTH`, 8, byte width of the scratch memory and the key bytes
- `ADDR_WIDTH`, 8, scratch address width (256 entries)
- `KEY_BYTES`, 3, number of key bytes cycled through the schedule

- `clk`  in  1  single clock, all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  level request; sampled only in IDLE
- `secret_key`  in  8*KEY_BYTES  key; byte 0 = `secret_key[23:16]`, byte 2 = `[7:0]`; latched when `start` is sampled
- `s_addr`  out  ADDR_WIDTH  scratch address
- `s_data`  out  DATA_WIDTH  scratch write data
- `s_wren`  out  1  scratch write enable
- `s_q`  in  DATA_WIDTH  scratch read data, valid one cycle after `s_addr` is presented
- `finish`  out  1  high while in DONE

## Operation
- All outputs are registered. Reset values:
  - `s_addr` = 0, `s_data` = 0, `s_wren` = 0, `finish` = 0
  - i = 0, j = 0, key index k = 0, state = IDLE
- IDLE: when `start` = 1, latch `secret_key` and clear i, j, k. Next state is INIT if the init feature is compiled in, otherwise RD_I.
- INIT: each cycle write s[i] = i (`s_wren` = 1). i increments. After i = 255, i wraps to 0 and the next state is RD_I.
- Swap loop, one iteration per i = 0..255, six states:
  - RD_I: `s_addr` = i.
  - CAP_I: latch si = `s_q`. Then j <= j + si + key[k], computed mod 256 (8-bit wrap, carries discarded).
  - RD_J: `s_addr` = j.
  - CAP_J: latch sj = `s_q`.
  - WR_I: `s_addr` = i, `s_data` = sj, `s_wren` = 1.
  - WR_J: `s_addr` = j, `s_data` = si, `s_wren` = 1. Then k <= (k == KEY_BYTES-1) ? 0 : k+1. If i == 255, go to DONE; otherwise i <= i+1 and go to RD_I.
- k is a wrapping counter; no divider or modulo hardware.
- Case i == j: both writes store the same latched value, so S is unchanged. No special handling.
- The block never depends on write-through `s_q`; reads occur only in RD_I and RD_J, which are non-write cycles.
- DONE: `finish` = 1 and `s_wren` = 0. Stay in DONE while `start` = 1; go to IDLE when `start` = 0. Holding `start` high never re-triggers the block.
- `rst` in any state returns to IDLE with reset values on the next edge. Scratch contents are left partially updated and undefined to downstream.

## Timing
- E0 is the edge that samples `start` in IDLE.
- With init: INIT occupies the 256 cycles after E0. The swap loop occupies 1536 cycles (6 × 256). `finish` goes high after edge E0+1792.
- Without init: `finish` goes high after edge E0+1536.
- Read latency budget is exactly one cycle (RD to CAP). The memory must be synchronous-read, registered-output.
- At most one write per cycle. `s_wren` is never high outside INIT, WR_I and WR_J.
- `finish` falls on the edge after `start` is sampled low in DONE. At the earliest, the block can restart one cycle after that.

## Configuration
- `KSA_INIT_EN` defined:
  - INIT state is present; the block produces S from scratch.
  - Total run length is 1792 cycles.
- Not defined:
  - INIT state is removed; RD_I follows IDLE directly.
  - Scratch must be preloaded with the identity permutation by an external initializer.
  - Total run length is 1536 cycles.

## Test plan
- **Identity fill:** `KSA_INIT_EN`, key 24'h000000, break at the INIT→RD_I transition -> s[0..255] = 0..255 and exactly 256 write cycles counted.
- **Zero-key swaps:** `KSA_INIT_EN`, key 24'h000000, stop after 3 iterations -> s[0] = 0 and s[1] = 1 (i == j at i = 0 and i = 1), s[2] = 3, s[3] = 2, j = 3.
- **Full run against model:** key 24'h00033C -> final S matches a software RC4 KSA byte-for-byte; `finish` rises exactly 1792 cycles after E0, or 1536 without the macro when scratch is preloaded with identity.
- **Start held high:** keep `start` = 1 for 5000 cycles -> exactly one run; `finish` stays high; no `s_wren` after DONE. Drop `start` -> `finish` = 0 next edge; raising `start` again starts a second run.
- **Reset mid-run:** assert `rst` for 1 cycle during WR_I of iteration 100 -> next edge `s_wren` = 0, `finish` = 0, state IDLE. A subsequent full run with preloaded identity reproduces the model result.
- **Key byte order:** key 24'hFF0000 vs 24'h0000FF -> the first iteration computes j = 0xFF vs j = 0x00 respectively.

Source files
------------

// File: rtl/ksa_scheduler.sv
// ksa_scheduler
//   Runs the RC4 key-scheduling pass over a 256-entry scratch (S) memory.
//   It can optionally fill S with the identity permutation first. It then
//   performs the 256 key-driven swaps and raises `finish`, which gates the
//   downstream decrypter.
//
//   Optional feature macro: KSA_INIT_EN
//     defined     : an INIT phase writes s[i] = i before the swap loop
//                   (1792-cycle run).
//     not defined : the scratch must already hold the identity permutation
//                   (1536-cycle run).
//
// Ports
//   clk        in   single clock, rising-edge
//   rst        in   synchronous active-high reset
//   start      in   level request, sampled only in IDLE
//   secret_key in   key, byte 0 in the most significant byte
//   s_addr     out  scratch address (registered)
//   s_data     out  scratch write data (registered)
//   s_wren     out  scratch write enable (registered)
//   s_q        in   scratch read data, valid one cycle after s_addr
//   finish     out  high while in DONE (registered)

module ksa_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int KEY_BYTES  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [8*KEY_BYTES-1:0]  secret_key,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic [DATA_WIDTH-1:0]   s_data,
  output logic                    s_wren,
  input  logic [DATA_WIDTH-1:0]   s_q,
  output logic                    finish
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [3:0] {
    IDLE,
`ifdef KSA_INIT_EN
    INIT,
`endif
    RD_I,
    CAP_I,
    RD_J,
    CAP_J,
    WR_I,
    WR_J,
    DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   i;
  logic [ADDR_WIDTH-1:0]   j;
  logic [KW-1:0]           k;
  logic [8*KEY_BYTES-1:0]  key_reg;
  logic [DATA_WIDTH-1:0]   si;
  logic [DATA_WIDTH-1:0]   sj;
  logic [7:0]              key_byte;
  logic [ADDR_WIDTH-1:0]   j_next;

  // Select key byte k. Byte 0 sits in the top byte of the key word, so the
  // index runs downward from the MSB end. A small mux keeps k a plain
  // wrapping counter instead of needing i mod KEY_BYTES.
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (k == KW'(b)) begin
        key_byte = key_reg[8*(KEY_BYTES-1-b) +: 8];
      end
    end
  end

  // New j uses s[i] straight off the read port in CAP_I. The same value is
  // latched into si on that edge, so j and the RD_J address agree. The sum
  // wraps at 256 by width truncation.
  assign j_next = j + ADDR_WIDTH'(s_q) + ADDR_WIDTH'(key_byte);

  // Main sequencer. Every output is registered. The values assigned on an
  // edge are the ones the memory sees during the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      key_reg <= '0;
      si      <= '0;
      sj      <= '0;
      s_addr  <= '0;
      s_data  <= '0;
      s_wren  <= 1'b0;
      finish  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          s_wren <= 1'b0;
          finish <= 1'b0;
          if (start) begin
            key_reg <= secret_key;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            s_addr  <= '0;
`ifdef KSA_INIT_EN
            s_data  <= '0;
            s_wren  <= 1'b1;
            state   <= INIT;
`else
            state   <= RD_I;
`endif
          end
        end

`ifdef KSA_INIT_EN
        // Identity fill: this cycle writes s[i] = i. The next cycle's
        // write is set up here.
        INIT: begin
          if (&i) begin
            i      <= '0;
            s_addr <= '0;
            s_wren <= 1'b0;
            state  <= RD_I;
          end else begin
            i      <= i + ADDR_WIDTH'(1);
            s_addr <= i + ADDR_WIDTH'(1);
            s_data <= DATA_WIDTH'(i + ADDR_WIDTH'(1));
            s_wren <= 1'b1;
          end
        end
`endif

        RD_I: begin
          state <= CAP_I;
        end

        CAP_I: begin
          si     <= s_q;
          j      <= j_next;
          s_addr <= j_next;
          state  <= RD_J;
        end

        RD_J: begin
          state <= CAP_J;
        end

        // When i == j, both writes below store the same value, so S is
        // left unchanged.
        CAP_J: begin
          sj     <= s_q;
          s_addr <= i;
          s_data <= s_q;
          s_wren <= 1'b1;
          state  <= WR_I;
        end

        WR_I: begin
          s_addr <= j;
          s_data <= si;
          s_wren <= 1'b1;
          state  <= WR_J;
        end

        WR_J: begin
          s_wren <= 1'b0;
          k      <= (k == KW'(KEY_BYTES-1)) ? '0 : k + KW'(1);
          if (&i) begin
            finish <= 1'b1;
            state  <= DONE;
          end else begin
            i      <= i + ADDR_WIDTH'(1);
            s_addr <= i + ADDR_WIDTH'(1);
            state  <= RD_I;
          end
        end

        // Stay here while start is held, so one request gives one run.
        DONE: begin
          s_wren <= 1'b0;
          if (!start) begin
            finish <= 1'b0;
            state  <= IDLE;
          end
        end

        default: begin
          s_wren <= 1'b0;
          finish <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
